// File: rtl/led_matrix_scanner.sv
// Row-scan driver for a 5x7 LED matrix. It turns the divider's row-rate and image-rate square waves
// into one-cycle ticks, then scans one row per tick with a blanking gap, swapping frames only at row 0.
module led_matrix_scanner #(
    parameter int BLANK_CYCLES = 4,
    parameter int NUM_ROWS     = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        row_clk_in,
    input  logic        img_clk_in,
    input  logic [34:0] frame_a,
    input  logic [34:0] frame_b,
    output logic [6:0]  linhas,
    output logic [4:0]  colunas,
    output logic [2:0]  row_index,
    output logic        frame_sel,
    output logic        frame_start
);
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES);
    localparam logic [2:0] LAST_ROW   = 3'(NUM_ROWS - 1);

    state_t      state_reg, state_next;
    logic [7:0]  blank_cnt_reg, blank_cnt_next;
    logic [2:0]  row_reg, row_next;
    logic        frame_sel_reg, frame_sel_next;
    logic        pending_reg, pending_next;
    logic [34:0] shadow_reg, shadow_next;
    logic [6:0]  linhas_reg, linhas_next;
    logic [4:0]  colunas_reg, colunas_next;
    logic        frame_start_reg, frame_start_next;

    logic [1:0]  async_in;
    logic [1:0]  tick;
    logic        row_tick, img_tick;
    logic [34:0] frame_src;
    logic [4:0]  row_pix [NUM_ROWS];
    logic [6:0]  row_drive_n;

    assign async_in = {img_clk_in, row_clk_in};

    genvar gi;
    generate
        // Bit 0 is the row clock, bit 1 the image clock; only rising edges produce a tick.
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_sync
            logic s1_reg, s2_reg, hist_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    s1_reg   <= 1'b0;
                    s2_reg   <= 1'b0;
                    hist_reg <= 1'b0;
                end else begin
                    s1_reg   <= async_in[gi];
                    s2_reg   <= s1_reg;
                    hist_reg <= s2_reg;
                end
            end
            assign tick[gi] = s2_reg & ~hist_reg;
        end
    endgenerate

    assign row_tick     = tick[0];
    assign img_tick     = tick[1];
    assign pending_next = pending_reg ^ img_tick;

    // Row 0 sees the freshly selected frame, including a toggle from this very cycle.
    assign frame_src = (row_reg == 3'd0) ? (pending_next ? frame_b : frame_a) : shadow_reg;

    generate
        for (gi = 0; gi < NUM_ROWS; gi = gi + 1) begin : g_rows
            assign row_pix[gi]     = frame_src[5*gi +: 5];
            assign row_drive_n[gi] = (row_reg != 3'(gi));
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        blank_cnt_next   = blank_cnt_reg;
        row_next         = row_reg;
        frame_sel_next   = frame_sel_reg;
        shadow_next      = shadow_reg;
        linhas_next      = linhas_reg;
        colunas_next     = colunas_reg;
        frame_start_next = 1'b0;

        if (!enable) begin
            state_next     = IDLE;
            blank_cnt_next = 8'd0;
            row_next       = 3'd0;
            linhas_next    = 7'h7F;
            colunas_next   = 5'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    linhas_next  = 7'h7F;
                    colunas_next = 5'd0;
                    if (row_tick) begin
                        state_next     = BLANK;
                        blank_cnt_next = BLANK_LOAD;
                    end
                end
                BLANK: begin
                    linhas_next    = 7'h7F;
                    blank_cnt_next = blank_cnt_reg - 8'd1;
                    if (blank_cnt_reg == 8'd1) begin
                        state_next   = DRIVE;
                        shadow_next  = frame_src;
                        colunas_next = row_pix[row_reg];
                        linhas_next  = row_drive_n;
                        if (row_reg == 3'd0) begin
                            frame_sel_next   = pending_next;
                            frame_start_next = 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    if (row_tick) begin
                        row_next       = (row_reg == LAST_ROW) ? 3'd0 : row_reg + 3'd1;
                        state_next     = BLANK;
                        blank_cnt_next = BLANK_LOAD;
                        linhas_next    = 7'h7F;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            blank_cnt_reg   <= 8'd0;
            row_reg         <= 3'd0;
            frame_sel_reg   <= 1'b0;
            pending_reg     <= 1'b0;
            shadow_reg      <= 35'd0;
            linhas_reg      <= 7'h7F;
            colunas_reg     <= 5'd0;
            frame_start_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            blank_cnt_reg   <= blank_cnt_next;
            row_reg         <= row_next;
            frame_sel_reg   <= frame_sel_next;
            pending_reg     <= pending_next;
            shadow_reg      <= shadow_next;
            linhas_reg      <= linhas_next;
            colunas_reg     <= colunas_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign linhas      = linhas_reg;
    assign colunas     = colunas_reg;
    assign row_index   = row_reg;
    assign frame_sel   = frame_sel_reg;
    assign frame_start = frame_start_reg;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: random row/image clocks, frame changes, enable drops and resets,
// compared every cycle against a phase-level model (idle / gap / lit row) of the scanner.
module tb_led_matrix_scanner;
    localparam int BLANK = 4;

    logic        clock = 1'b0;
    logic        reset, enable, row_clk_in, img_clk_in;
    logic [34:0] frame_a, frame_b;
    logic [6:0]  linhas;
    logic [4:0]  colunas;
    logic [2:0]  row_index;
    logic        frame_sel, frame_start;

    int checks = 0;
    int errors = 0;

    always #10 clock = ~clock;

    led_matrix_scanner #(.BLANK_CYCLES(BLANK), .NUM_ROWS(7)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .row_clk_in(row_clk_in), .img_clk_in(img_clk_in),
        .frame_a(frame_a), .frame_b(frame_b),
        .linhas(linhas), .colunas(colunas), .row_index(row_index),
        .frame_sel(frame_sel), .frame_start(frame_start)
    );

    // Model: mode 0 = dark/idle, 1 = blanking gap, 2 = row lit.
    int          m_mode, m_gap, m_row;
    bit          m_fsel, m_pend, m_fs;
    logic [34:0] m_shadow;
    logic [6:0]  m_lin;
    logic [4:0]  m_col;
    bit   [2:0]  rh, ih;   // [0] newest sampled input level

    // Stimulus knobs (per-mille probabilities)
    bit auto_row;
    int rc_left, hp_lo, hp_hi, img_pm, fr_pm, en_pm, rst_pm, en_hold;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rt, it, pn;
        if (reset) begin
            m_mode = 0; m_gap = 0; m_row = 0; m_fsel = 0; m_pend = 0; m_fs = 0;
            m_shadow = '0; m_lin = 7'h7F; m_col = '0; rh = '0; ih = '0;
            return;
        end
        rt = rh[1] & ~rh[2];
        it = ih[1] & ~ih[2];
        rh = {rh[1:0], row_clk_in};
        ih = {ih[1:0], img_clk_in};
        pn = m_pend ^ it;
        m_fs = 0;
        if (!enable) begin
            m_mode = 0; m_row = 0; m_lin = 7'h7F; m_col = '0;
        end else if (m_mode == 0) begin
            if (rt) begin m_mode = 1; m_gap = BLANK; end
        end else if (m_mode == 1) begin
            m_gap--;
            if (m_gap == 0) begin
                if (m_row == 0) begin
                    m_fsel = pn;
                    m_shadow = pn ? frame_b : frame_a;
                    m_fs = 1;
                    $display("frame start: frame %0d row0 %b at %0t", pn, m_shadow[4:0], $time);
                end
                m_col = m_shadow[m_row*5 +: 5];
                m_lin = ~(7'b1 << m_row);
                m_mode = 2;
            end
        end else if (rt) begin
            m_row = (m_row + 1) % 7;
            m_mode = 1; m_gap = BLANK; m_lin = 7'h7F;
        end
        m_pend = pn;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check("linhas", linhas, m_lin);
        check("colunas", colunas, m_col);
        check("row_index", row_index, m_row);
        check("frame_sel", frame_sel, m_fsel);
        check("frame_start", frame_start, m_fs);
    endtask

    task automatic gen_inputs();
        if (auto_row) begin
            if (rc_left <= 0) begin
                row_clk_in = ~row_clk_in;
                rc_left = $urandom_range(hp_hi, hp_lo);
            end else rc_left--;
        end
        if ($urandom_range(999, 0) < img_pm) img_clk_in = ~img_clk_in;
        if ($urandom_range(999, 0) < fr_pm) frame_a = 35'({$urandom(), $urandom()});
        if ($urandom_range(999, 0) < fr_pm) frame_b = 35'({$urandom(), $urandom()});
        if (en_hold > 0) begin
            en_hold--;
            if (en_hold == 0) enable = 1'b1;
        end else if ($urandom_range(999, 0) < en_pm) begin
            enable = 1'b0;
            en_hold = $urandom_range(6, 1);
        end
        reset = ($urandom_range(999, 0) < rst_pm);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            gen_inputs();
            cycle();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; row_clk_in = 1'b0; img_clk_in = 1'b0;
        frame_a = 35'h1_2345_6789; frame_b = 35'h2_AAAA_5555;
        auto_row = 0; rc_left = 0; hp_lo = 11; hp_hi = 11;
        img_pm = 0; fr_pm = 0; en_pm = 0; rst_pm = 0; en_hold = 0;

        // Reset values with enable high, then a regular row clock through more than one frame.
        do_reset();
        check("reset_linhas", linhas, 7'h7F);
        check("reset_row", row_index, 3'd0);
        auto_row = 1;
        run(220);

        // Image tick landing exactly on the row-0 load edge.
        auto_row = 0; row_clk_in = 1'b0; img_clk_in = 1'b0;
        do_reset();
        row_clk_in = 1'b1;
        cycle();
        repeat (BLANK - 1) cycle();
        img_clk_in = 1'b1;
        repeat (3) cycle();
        check("same_cycle_fs", frame_start, 1'b1);
        check("same_cycle_sel", frame_sel, 1'b1);
        check("same_cycle_cols", colunas, frame_b[4:0]);

        // Image flips and frame_a/frame_b changes mid-frame.
        auto_row = 1; rc_left = 0; hp_lo = 8; hp_hi = 16; img_pm = 15; fr_pm = 20;
        run(800);

        // Everything random: short row periods (ticks in the gap), enable drops, resets.
        hp_lo = 0; hp_hi = 12; img_pm = 30; fr_pm = 30; en_pm = 8; rst_pm = 3;
        run(2500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
